// File: rtl/spi_master_engine.sv
// ----------------------------------------------------------------------------
// spi_master_engine
//   Parametrised SPI master shift engine. Accepts one word per valid/ready
//   handshake on the TX port, runs the SPI frame with the latched
//   configuration, and returns the received word as a one-cycle rx_valid_o
//   pulse.
//
//   Frame phases: LEAD (CS low, one half period), XFER (2*(len+1) SCK
//   half periods), TRAIL (SCK back at idle level, CS still low, one half
//   period), GAP (CS high, one half period).
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   cfg_cpol_i/cpha_i/lsb_i SPI mode and bit order
//   cfg_div_i               SCK half period = cfg_div_i+1 clk cycles
//   cfg_len_i               bits per transfer minus 1
//   cfg_cs_i                chip-select index (>= CS_NUM asserts nothing)
//   tx_valid_i/tx_ready_o   request handshake, tx_data_i right-aligned
//   rx_valid_o/rx_data_o    received word, right-aligned, zero-extended
//   busy_o                  transfer in progress
//   spi_sck_o/spi_csn_o/spi_mosi_o/spi_miso_i  SPI pins
//
// Optional build macro:
//   SPI_LOOPBACK_EN  adds cfg_loop_i; when latched high, received bits are
//                    taken from the internal MOSI instead of spi_miso_i.
// ----------------------------------------------------------------------------
module spi_master_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int CS_NUM     = 4,
    parameter int DIV_WIDTH  = 16,
    parameter int LEN_WIDTH  = $clog2(DATA_WIDTH),
    parameter int CS_W       = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_cpol_i,
    input  logic                  cfg_cpha_i,
    input  logic                  cfg_lsb_i,
    input  logic [DIV_WIDTH-1:0]  cfg_div_i,
    input  logic [LEN_WIDTH-1:0]  cfg_len_i,
    input  logic [CS_W-1:0]       cfg_cs_i,
`ifdef SPI_LOOPBACK_EN
    input  logic                  cfg_loop_i,
`endif
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  rx_valid_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  busy_o,
    output logic                  spi_sck_o,
    output logic [CS_NUM-1:0]     spi_csn_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_XFER,
        ST_TRAIL,
        ST_GAP
    } state_t;

    state_t                state;
    logic                  cpol_q;
    logic                  cpha_q;
    logic                  lsb_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [DIV_WIDTH-1:0]  timer;
    logic [LEN_WIDTH:0]    edge_cnt;

    logic                  tick;
    logic                  last_edge;
    logic                  sample_now;
    logic                  drive_now;
    logic [LEN_WIDTH-1:0]  bit_k;
    logic [LEN_WIDTH-1:0]  drive_k;
    logic [LEN_WIDTH-1:0]  rx_idx;
    logic [LEN_WIDTH-1:0]  tx_idx;
    logic [LEN_WIDTH-1:0]  first_idx;
    logic [CS_NUM-1:0]     csn_sel;
    logic                  miso_bit;

`ifdef SPI_LOOPBACK_EN
    logic loop_q;
    assign miso_bit = loop_q ? spi_mosi_o : spi_miso_i;
`else
    assign miso_bit = spi_miso_i;
`endif

    assign tick = (state != ST_IDLE) && (timer == div_q);

    // edge_cnt is the 0-based index of the SCK edge about to be produced.
    // Each bit spans two edges, so edge_cnt/2 is the bit being handled.
    // CPHA=0 samples on even edge_cnt (1st,3rd,.. edge) and shifts on odd;
    // CPHA=1 is the reverse, with the drive happening before the sample of
    // the same bit.
    assign last_edge  = (edge_cnt == {len_q, 1'b1});
    assign sample_now = cpha_q ? edge_cnt[0] : ~edge_cnt[0];
    assign drive_now  = ~sample_now & ~last_edge;
    assign bit_k      = edge_cnt[LEN_WIDTH:1];
    assign drive_k    = cpha_q ? bit_k : bit_k + 1'b1;
    assign rx_idx     = lsb_q ? bit_k   : len_q - bit_k;
    assign tx_idx     = lsb_q ? drive_k : len_q - drive_k;
    assign first_idx  = cfg_lsb_i ? '0 : cfg_len_i;

    always_comb begin
        csn_sel = '1;
        for (int unsigned i = 0; i < CS_NUM; i++) begin
            if (32'(cfg_cs_i) == i) csn_sel[i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            tx_ready_o <= 1'b1;
            rx_valid_o <= 1'b0;
            rx_data_o  <= '0;
            busy_o     <= 1'b0;
            spi_sck_o  <= 1'b0;
            spi_csn_o  <= '1;
            spi_mosi_o <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            div_q      <= '0;
            len_q      <= '0;
            tx_q       <= '0;
            rx_sr      <= '0;
            timer      <= '0;
            edge_cnt   <= '0;
`ifdef SPI_LOOPBACK_EN
            loop_q     <= 1'b0;
`endif
        end else begin
            rx_valid_o <= 1'b0;
            if (state != ST_IDLE) timer <= tick ? '0 : timer + 1'b1;

            case (state)
                ST_IDLE: begin
                    spi_sck_o <= cfg_cpol_i;
                    spi_csn_o <= '1;
                    if (tx_valid_i && tx_ready_o) begin
                        cpol_q     <= cfg_cpol_i;
                        cpha_q     <= cfg_cpha_i;
                        lsb_q      <= cfg_lsb_i;
                        div_q      <= cfg_div_i;
                        len_q      <= cfg_len_i;
                        tx_q       <= tx_data_i;
`ifdef SPI_LOOPBACK_EN
                        loop_q     <= cfg_loop_i;
`endif
                        rx_sr      <= '0;
                        timer      <= '0;
                        edge_cnt   <= '0;
                        spi_csn_o  <= csn_sel;
                        spi_mosi_o <= cfg_cpha_i ? 1'b0 : tx_data_i[first_idx];
                        tx_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                        state      <= ST_LEAD;
                    end
                end
                ST_LEAD: begin
                    if (tick) begin
                        edge_cnt <= '0;
                        state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (tick) begin
                        spi_sck_o <= ~spi_sck_o;
                        edge_cnt  <= edge_cnt + 1'b1;
                        if (sample_now) rx_sr[rx_idx] <= miso_bit;
                        if (drive_now)  spi_mosi_o    <= tx_q[tx_idx];
                        if (last_edge)  state         <= ST_TRAIL;
                    end
                end
                ST_TRAIL: begin
                    spi_sck_o <= cpol_q;
                    if (tick) begin
                        spi_csn_o  <= '1;
                        rx_data_o  <= rx_sr;
                        rx_valid_o <= 1'b1;
                        state      <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        spi_mosi_o <= 1'b0;
                        busy_o     <= 1'b0;
                        tx_ready_o <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_engine.sv
`timescale 1ns/1ps
// Bench for spi_master_engine: table-driven directed transfers, randomized
// transfers against a behavioural SPI slave, plus back-to-back and
// mid-transfer reset sequences.
module tb_spi_master_engine;

    localparam int DW   = 32;
    localparam int CSN  = 4;
    localparam int DIVW = 16;
    localparam int LENW = 5;
    localparam int CSW  = 2;
    localparam int BUDGET = 5000;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_cpol, cfg_cpha, cfg_lsb;
    logic [DIVW-1:0] cfg_div;
    logic [LENW-1:0] cfg_len;
    logic [CSW-1:0]  cfg_cs;
`ifdef SPI_LOOPBACK_EN
    logic            cfg_loop;
`endif
    logic            tx_valid;
    logic            tx_ready;
    logic [DW-1:0]   tx_data;
    logic            rx_valid;
    logic [DW-1:0]   rx_data;
    logic            busy;
    logic            spi_sck;
    logic [CSN-1:0]  spi_csn;
    logic            spi_mosi;
    logic            spi_miso;

    always #5 clk = ~clk;

    spi_master_engine #(
        .DATA_WIDTH(DW),
        .CS_NUM    (CSN),
        .DIV_WIDTH (DIVW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cfg_cpol_i (cfg_cpol),
        .cfg_cpha_i (cfg_cpha),
        .cfg_lsb_i  (cfg_lsb),
        .cfg_div_i  (cfg_div),
        .cfg_len_i  (cfg_len),
        .cfg_cs_i   (cfg_cs),
`ifdef SPI_LOOPBACK_EN
        .cfg_loop_i (cfg_loop),
`endif
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .tx_data_i  (tx_data),
        .rx_valid_o (rx_valid),
        .rx_data_o  (rx_data),
        .busy_o     (busy),
        .spi_sck_o  (spi_sck),
        .spi_csn_o  (spi_csn),
        .spi_mosi_o (spi_mosi),
        .spi_miso_i (spi_miso)
    );

    // ---------------- behavioural SPI slave ----------------
    logic          sl_cpol = 1'b0, sl_cpha = 1'b0, sl_lsb = 1'b0;
    int            sl_len = 0;
    logic [31:0]   sl_word = '0;
    logic          miso_tie0 = 1'b0;
    logic          miso_drv = 1'b0;
    logic          sl_active = 1'b0;
    int            sl_ktx = 0, sl_krx = 0;
    logic [31:0]   sl_mosi_word = '0;
    logic [CSN-1:0] csn_seen = '1;
    logic [CSN-1:0] csn_prev = '1;
    logic          sck_prev = 1'b0;
    int            toggles = 0;
    logic          in_xfer = 1'b0;
    logic          lead;

    assign spi_miso = miso_tie0 ? 1'b0 : miso_drv;

    function automatic logic sl_bit(input int k);
        if (k > sl_len) return 1'b0;
        return sl_word[sl_lsb ? k : sl_len - k];
    endfunction

    always @(spi_sck or spi_csn) begin
        if (spi_sck !== sck_prev) begin
            sck_prev = spi_sck;
            if (in_xfer) toggles++;
            if (sl_active) begin
                lead = (spi_sck != sl_cpol);
                if (lead != sl_cpha) begin
                    if (sl_krx <= sl_len)
                        sl_mosi_word[sl_lsb ? sl_krx : sl_len - sl_krx] = spi_mosi;
                    sl_krx++;
                end else if (sl_cpha) begin
                    miso_drv = sl_bit(sl_ktx);
                    sl_ktx++;
                end else begin
                    sl_ktx++;
                    miso_drv = sl_bit(sl_ktx);
                end
            end
        end
        if (spi_csn !== csn_prev) begin
            csn_prev = spi_csn;
            if (spi_csn != '1) begin
                if (!sl_active) begin
                    sl_active    = 1'b1;
                    csn_seen     = spi_csn;
                    sl_ktx       = 0;
                    sl_krx       = 0;
                    sl_mosi_word = '0;
                    if (!sl_cpha) miso_drv = sl_bit(0);
                end
            end else begin
                sl_active = 1'b0;
                miso_drv  = 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          cpol;
        bit          cpha;
        bit          lsb;
        bit          loop;
        int          div;
        int          len;
        int          cs;
        logic [31:0] tx;
        logic [31:0] sl;
        logic [31:0] exp_rx;
        logic [31:0] exp_mosi;
        logic [3:0]  exp_csn;
    } vec_t;

    task automatic apply_cfg(input vec_t v);
        cfg_cpol = v.cpol;
        cfg_cpha = v.cpha;
        cfg_lsb  = v.lsb;
        cfg_div  = DIVW'(v.div);
        cfg_len  = LENW'(v.len);
        cfg_cs   = CSW'(v.cs);
`ifdef SPI_LOOPBACK_EN
        cfg_loop = v.loop;
`endif
    endtask

    task automatic run_xfer(input vec_t v, input string tag);
        int n;
        int m;
        int t0;
        int k_exp;
        logic [31:0] rx_got;
        @(negedge clk);
        apply_cfg(v);
        tx_data   = v.tx;
        sl_cpol   = v.cpol;
        sl_cpha   = v.cpha;
        sl_lsb    = v.lsb;
        sl_len    = v.len;
        sl_word   = v.sl;
        miso_tie0 = v.loop;
        repeat (2) @(negedge clk);
        chk({tag, ".sck_idle"}, spi_sck, v.cpol);
        t0 = toggles;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".ready"}, tx_ready, 1);
        @(posedge clk);
        #1 in_xfer = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk({tag, ".busy"}, {busy, tx_ready}, 2'b10);
        // configuration changes during the frame must not matter
        cfg_cpol = ~v.cpol;
        cfg_cpha = ~v.cpha;
        cfg_lsb  = ~v.lsb;
        cfg_div  = DIVW'($urandom);
        cfg_len  = LENW'($urandom);
        cfg_cs   = CSW'($urandom);
        tx_data  = $urandom;
`ifdef SPI_LOOPBACK_EN
        cfg_loop = ~v.loop;
`endif
        n = 0;
        while (!rx_valid && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        k_exp = (v.div + 1) * (2 * (v.len + 1) + 2);
        chk({tag, ".rx_valid"}, rx_valid, 1);
        chk({tag, ".cycles"}, n, k_exp);
        chk({tag, ".rx_data"}, rx_data, v.exp_rx);
        rx_got = rx_data;
        apply_cfg(v);
        m = 0;
        @(negedge clk);
        m++;
        chk({tag, ".rx_pulse"}, rx_valid, 0);
        while (busy && m < BUDGET) begin
            @(negedge clk);
            m++;
        end
        chk({tag, ".gap"}, m, v.div + 1);
        chk({tag, ".idle"}, {busy, tx_ready, spi_csn}, {2'b01, 4'hF});
        in_xfer = 1'b0;
        chk({tag, ".toggles"}, toggles - t0, 2 * (v.len + 1));
        chk({tag, ".mosi"}, sl_mosi_word, v.exp_mosi);
        chk({tag, ".csn"}, csn_seen, v.exp_csn);
        @(negedge clk);
        chk({tag, ".rx_hold"}, rx_data, rx_got);
        chk({tag, ".sck_end"}, spi_sck, v.cpol);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        logic [63:0] mask;
        v.cpol = 1'($urandom_range(0, 1));
        v.cpha = 1'($urandom_range(0, 1));
        v.lsb  = 1'($urandom_range(0, 1));
        v.loop = 1'b0;
        v.div  = int'($urandom_range(0, 3));
        v.len  = int'($urandom_range(0, 31));
        v.cs   = int'($urandom_range(0, 3));
        v.tx   = $urandom;
        v.sl   = $urandom;
        mask   = (64'd1 << (v.len + 1)) - 64'd1;
        v.exp_rx   = v.sl & mask[31:0];
        v.exp_mosi = v.tx & mask[31:0];
        v.exp_csn  = ~(4'b0001 << v.cs);
        return v;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    vec_t tbl[$];
    vec_t v;
    int   n;
    int   words;
    int   gap;
    int   ready_while_busy;
    int   pulses;
    int   t0;
    bit   seen_low;
    bit   in_gap;
    logic [31:0] rx_w[2];
    logic [31:0] mosi_w[2];

    initial begin
        rst      = 1'b1;
        cfg_cpol = 1'b1;
        cfg_cpha = 1'b0;
        cfg_lsb  = 1'b0;
        cfg_div  = '0;
        cfg_len  = '0;
        cfg_cs   = '0;
`ifdef SPI_LOOPBACK_EN
        cfg_loop = 1'b0;
`endif
        tx_valid = 1'b0;
        tx_data  = '0;

        //               cpol cpha lsb loop div len cs  tx            sl            exp_rx        exp_mosi      csn
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1, 7,  2, 32'h0000_00A5, 32'h0000_003C, 32'h0000_003C, 32'h0000_00A5, 4'b1011});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1, 15, 0, 32'h0000_1234, 32'h0000_5AC3, 32'h0000_5AC3, 32'h0000_1234, 4'b1110});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2, 15, 1, 32'h0000_1234, 32'h0000_5AC3, 32'h0000_5AC3, 32'h0000_1234, 4'b1101});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 15, 3, 32'h0000_1234, 32'h0000_5AC3, 32'h0000_5AC3, 32'h0000_1234, 4'b0111});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 3, 15, 0, 32'h0000_1234, 32'h0000_5AC3, 32'h0000_5AC3, 32'h0000_1234, 4'b1110});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 0, 31, 1, 32'h8000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0001, 4'b1101});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1, 7,  3, 32'hFFFF_FF5A, 32'h1234_5681, 32'h0000_0081, 32'h0000_005A, 4'b0111});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1, 0,  2, 32'h0000_0003, 32'h0000_0002, 32'h0000_0000, 32'h0000_0001, 4'b1011});
`ifdef SPI_LOOPBACK_EN
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1, 7,  0, 32'h0000_00C3, 32'h0000_0055, 32'h0000_00C3, 32'h0000_00C3, 4'b1110});
`endif

        // reset values, with cpol=1 requested while still in reset
        repeat (3) @(negedge clk);
        chk("reset.ready_valid_busy", {tx_ready, rx_valid, busy}, 3'b100);
        chk("reset.rx_data", rx_data, 0);
        chk("reset.pins", {spi_sck, spi_csn, spi_mosi}, {1'b0, 4'hF, 1'b0});
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.sck_follows_cpol", spi_sck, 1);
        cfg_cpol = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run_xfer(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 24; i++) begin
            v = rand_vec();
            run_xfer(v, $sformatf("rnd%0d", i));
        end

        // back-to-back: tx_valid held high across two words
        @(negedge clk);
        v = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 7, 1, 32'h3C, 32'h96, 32'h96, 32'h3C, 4'b1101};
        apply_cfg(v);
        sl_cpol = 1'b0; sl_cpha = 1'b0; sl_lsb = 1'b0; sl_len = 7;
        sl_word = 32'h96; miso_tie0 = 1'b0;
        tx_data = 32'h3C;
        repeat (2) @(negedge clk);
        tx_valid = 1'b1;
        words = 0; gap = 0; ready_while_busy = 0; seen_low = 0; in_gap = 0;
        n = 0;
        while (n < BUDGET && !(words == 2 && !busy)) begin
            @(negedge clk);
            n++;
            if (busy && tx_ready) ready_while_busy++;
            if (busy && tx_data == 32'h3C) tx_data = 32'hC5;
            if (spi_csn != 4'hF) begin
                seen_low = 1'b1;
                in_gap   = 1'b0;
            end else if (seen_low && words == 1) begin
                in_gap = 1'b1;
                gap++;
            end
            if (rx_valid) begin
                if (words < 2) begin
                    rx_w[words]   = rx_data;
                    mosi_w[words] = sl_mosi_word;
                end
                words++;
                sl_word = 32'h69;
            end
        end
        tx_valid = 1'b0;
        chk("b2b.words", words, 2);
        chk("b2b.rx0", rx_w[0], 32'h96);
        chk("b2b.rx1", rx_w[1], 32'h69);
        chk("b2b.mosi0", mosi_w[0], 32'h3C);
        chk("b2b.mosi1", mosi_w[1], 32'hC5);
        chk("b2b.ready_while_busy", ready_while_busy, 0);
        chk("b2b.csn_gap_min", gap >= v.div + 1, 1);
        repeat (2) @(negedge clk);

        // reset asserted at the 5th SCK edge
        v = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 15, 0, 32'hABCD, 32'h1357, 32'h1357, 32'hABCD, 4'b1110};
        apply_cfg(v);
        sl_cpol = 1'b0; sl_cpha = 1'b0; sl_lsb = 1'b0; sl_len = 15; sl_word = 32'h1357;
        tx_data = 32'hABCD;
        repeat (2) @(negedge clk);
        tx_valid = 1'b1;
        @(posedge clk);
        #1 in_xfer = 1'b1;
        t0 = toggles;
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (toggles - t0 < 5 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("rst.reached_edge5", toggles - t0, 5);
        rst = 1'b1;
        #1;
        chk("rst.pins", {spi_sck, spi_csn, spi_mosi}, {1'b0, 4'hF, 1'b0});
        chk("rst.status", {tx_ready, rx_valid, busy}, 3'b100);
        chk("rst.rx_data", rx_data, 0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 3) rst = 1'b0;
            if (rx_valid) pulses++;
        end
        in_xfer = 1'b0;
        chk("rst.no_rx_pulse", pulses, 0);
        chk("rst.ready_after", tx_ready, 1);
        run_xfer(v, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master_engine.md
Name: spi_master_engine

Overview:
- Parametrised SPI master shift engine; successor to the fixed-format SPI core behind the apb4_spi register wrapper.
- Adds configurable word length, all four CPOL/CPHA modes, MSB/LSB-first ordering, programmable SCK divider and multiple chip selects.
- Fed by the register or FIFO layer through a valid/ready TX port; returns one RX word per transfer.

Parameters:
- DATA_WIDTH, 32, maximum bits per transfer.
- CS_NUM, 4, number of active-low chip selects.
- DIV_WIDTH, 16, width of the clock-divider field.
- LEN_WIDTH, $clog2(DATA_WIDTH), width of the length field.
- CS_W, (CS_NUM>1)?$clog2(CS_NUM):1, width of the CS index.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- cfg_cpol_i  in  1  SCK idle level
- cfg_cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge
- cfg_lsb_i  in  1  1: LSB first
- cfg_div_i  in  DIV_WIDTH  SCK half period = cfg_div_i+1 clk cycles
- cfg_len_i  in  LEN_WIDTH  bits per transfer minus 1
- cfg_cs_i  in  CS_W  chip-select index
- tx_valid_i  in  1  transfer request
- tx_ready_o  out  1  engine accepts a request
- tx_data_i  in  DATA_WIDTH  data to send, right-aligned
- rx_valid_o  out  1  one-cycle pulse, received word valid
- rx_data_o  out  DATA_WIDTH  received word, right-aligned, zero-extended
- busy_o  out  1  transfer in progress
- spi_sck_o  out  1  serial clock
- spi_csn_o  out  CS_NUM  chip selects, active low
- spi_mosi_o  out  1  master out
- spi_miso_i  in  1  master in

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values:
  - tx_ready_o=1, rx_valid_o=0, rx_data_o=0, busy_o=0.
  - spi_sck_o=0, spi_csn_o=all 1, spi_mosi_o=0.
  - FSM in IDLE. The SCK idle level follows cfg_cpol_i only once the engine leaves reset.
- Handshake:
  - A transfer is accepted on the cycle with tx_valid_i & tx_ready_o.
  - tx_data and all cfg_* are latched at acceptance. Later cfg changes do not affect a running transfer.
  - tx_ready_o=1 only in IDLE.
- Half-period timer: counts 0..cfg_div_i. A tick fires when the timer reaches cfg_div_i, then the timer restarts. cfg_div_i=0 gives one tick per clk.
- FSM:
  - IDLE: sck=cpol, csn all high. On accept, go to LEAD and set busy_o=1.
  - LEAD: csn[cs] low. For CPHA=0, mosi = first bit. After one tick, go to XFER.
  - XFER: 2*(len+1) ticks; each tick toggles sck.
    - CPHA=0: sample miso on odd edges (1,3,...), shift mosi on even edges, except after the final edge.
    - CPHA=1: drive mosi on odd edges, sample on even edges.
    - After the last edge, go to TRAIL.
  - TRAIL: sck=cpol, csn still low, lasts one tick. Then rx_data_o updates, rx_valid_o pulses for 1 cycle, and the FSM goes to GAP.
  - GAP: csn all high for one tick. Then IDLE, busy_o=0, tx_ready_o=1.
- Bit order:
  - MSB-first sends tx_data[len] down to tx_data[0].
  - LSB-first sends tx_data[0] up to tx_data[len].
  - RX is assembled into bits [len:0] in the same significance. Bits above len are 0.
  - tx_data bits above len are ignored.
- cfg_cs_i >= CS_NUM: the transfer runs normally with no CS asserted.
- rx_valid_o has no backpressure. rx_data_o holds its value until the next completion.
- Minimum back-to-back spacing: accepting in the cycle tx_ready_o rises is legal. CS is guaranteed high for at least one half period.
- Reset asserted mid-transfer: all outputs return to reset values immediately, with no rx_valid_o pulse.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- When defined:
  - Adds input cfg_loop_i (1 bit), latched at acceptance.
  - When the latched value is 1, the sampled bit comes from internal mosi instead of spi_miso_i.
  - Pins behave as in normal mode.
- When undefined: no port is added and sampling always uses spi_miso_i.

Test Plan:
- Mode 0, MSB, len=7, div=1, cs=2, tx=0xA5, slave returns 0x3C.
  - mosi sequence 1,0,1,0,0,1,0,1; spi_csn_o=4'b1011.
  - 8 rising edges, SCK period 4 clk; rx_data_o=0x0000003C, rx_valid_o 1 cycle.
- All four CPOL/CPHA modes with len=15, tx=0x1234, slave echo of model.
  - SCK idles at cpol; sample edge per table; rx_data_o=expected 16-bit word.
- LSB-first, len=31, div=0, tx=0x80000001.
  - First mosi bit 1, then 30 zeros, then 1; 64 sck toggles; busy_o low after GAP.
- Back-to-back transfers with tx_valid_i held high.
  - csn high for ≥ (div+1) clk between words; second word is not accepted while busy_o=1.
- rst_i asserted at the 5th SCK edge.
  - Same cycle: csn all high, sck=0, tx_ready_o=1 after release, no rx_valid_o.
  - The next transfer completes correctly.
- SPI_LOOPBACK_EN defined, cfg_loop_i=1, tx=0xC3, miso tied 0 → rx_data_o=0xC3.
